cordic_atan_vec: RTL and testbench
==================================

// Module: cordic_atan_vec
// PURPOSE
//  Vectoring-mode CORDIC: inverse of the rotation-mode cosine unit. Accepts an (x,y) pair
//  as IEEE-754 singles, drives y to zero, returns atan(y/x) as an IEEE-754 single.
//  Multi-cycle custom-instruction slave (start/done), UNROLLS micro-rotations per enabled cycle.
// PARAMETERS
//  UNROLLS  4   micro-rotations per enabled cycle; legal 1,2,4,8,16 (divides ITERS)
//  ITERS    16  total micro-rotations
//  XYW      23  x/y datapath width, signed Q2.20 (headroom for 1.647 CORDIC gain)
//  ZW       23  angle accumulator width, signed Q2.20 radians
// PORTS
//  clock   in   1   clock
//  aclr    in   1   synchronous active-high reset
//  clk_en  in   1   advance enable; all state frozen when low
//  start   in   1   load new operands (sampled only when clk_en=1)
//  dataa   in   32  x operand, IEEE single
//  datab   in   32  y operand, IEEE single
//  result  out  32  atan(y/x), IEEE single, radians
//  done    out  1   result valid; held until next start or aclr
// BEHAVIOUR
//  Reset (aclr=1 at posedge, overrides clk_en): state IDLE, iter=0, x=y=z=0, result=0, done=0, err=0.
//  FSM: IDLE -(start)-> RUN -(iter==ITERS)-> FIN -> DONE -(start)-> RUN. start in any state (incl. RUN)
//   aborts and reloads; done drops the cycle after the start edge.
//  Load (clk_en & start): x=fix(dataa), y=fix(datab), z=0, iter=0, done=0.
//   err=1 if dataa is <=0, zero/denormal, NaN or Inf, or datab is NaN/Inf.
//  fix(): sign-magnitude -> two's complement Q2.20, denormals flushed to 0, truncate toward zero;
//   |v|>=1.0 saturates to +/-(1-2^-20). Legal domain: 0<x<1, -1<y<1.
//  RUN, each enabled cycle: UNROLLS chained stages, stage k uses i=iter+k:
//   y>=0: x+=y>>>i, y-=x>>>i, z+=ATAN[i];  y<0: x-=y>>>i, y+=x>>>i, z-=ATAN[i].
//   >>> is arithmetic; all stages use pre-stage x,y. iter+=UNROLLS.
//  FIN: result<=err ? 32'h7FC00000 : flt(z); done<=1 next edge (DONE).
//  Latency: done high ITERS/UNROLLS+2 enabled edges after start edge (6 at UNROLLS=4).
//  flt(): z==0 -> +0.0; else sign, |z|, leading-one pos p -> exp=127+p-20, mantissa from bits
//   below p, truncated. Magnitude |z|<pi/2 so no overflow case.
//  clk_en=0: no state change, done/result hold; latency stretches 1:1 with stall cycles.
//  start & clk_en in DONE: new op, result keeps old value until FIN of new op.
//  Accuracy: |result-atan(y/x)| <= 2^-13 rad over legal domain.
// STRUCTURE
//  Package cordic_pkg: XYW/ZW/FRAC=20 localparams, ATAN[0:15] = round(atan(2^-i)*2^20)
//   (ATAN[0]=23'h0C90FE), state enum IDLE/RUN/FIN/DONE, NAN_Q=32'h7FC00000.
//  Sub-module cordic_vec_stage: one combinational micro-rotation (x,y,z,i,atan_i -> x',y',z'),
//   instantiated UNROLLS times via generate. Signed float<->fixed converters local to this file.
// TESTING
//  T1 dataa=3F000000 (0.5), datab=3F000000 -> done after 6 edges, result ~3F490FDB (pi/4), tol 2^-13.
//  T2 dataa=3F000000, datab=BF000000 -> result ~BF490FDB (-pi/4); sign bit set.
//  T3 dataa=3F000000, datab=00000000 -> |result|<=2^-13; dataa=00000000 -> result=7FC00000, normal latency.
//  T4 T1 with clk_en low 2 cycles mid-RUN -> done at edge 8, result bit-identical to T1.
//  T5 start T1, re-start with (0.5,0.25) at edge 3 -> no done from first op; result ~3EED6338 (0.46365)
//   6 edges after second start. aclr at edge 2 of any op -> done=0, result=0, stays IDLE.
//  T6 random 10k legal pairs vs real atan2 model; UNROLLS=1,4,16 sweep, latency = 16/UNROLLS+2.

Source files
------------

// File: rtl/cordic_pkg.sv
// Shared definitions for the vectoring-mode CORDIC arctangent unit.
//   XYW / ZW / FRAC : datapath widths (signed Q2.20 for x, y and the angle z)
//   state_e         : control FSM states
//   NAN_Q           : quiet NaN returned for illegal operands
//   atan_lut()      : round(atan(2^-i) * 2^20) for i = 0..15, zero beyond
package cordic_pkg;

    localparam int unsigned XYW  = 23;
    localparam int unsigned ZW   = 23;
    localparam int unsigned FRAC = 20;
    localparam int unsigned IdxW = 5;

    localparam logic [31:0] NAN_Q = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StFin,
        StDone
    } state_e;

    function automatic logic signed [ZW-1:0] atan_lut(input logic [IdxW-1:0] i);
        logic signed [ZW-1:0] a;
        case (i)
            5'd0:    a = 23'h0C90FE;
            5'd1:    a = 23'h076B1A;
            5'd2:    a = 23'h03EB6F;
            5'd3:    a = 23'h01FD5C;
            5'd4:    a = 23'h00FFAB;
            5'd5:    a = 23'h007FF5;
            5'd6:    a = 23'h003FFF;
            5'd7:    a = 23'h002000;
            5'd8:    a = 23'h001000;
            5'd9:    a = 23'h000800;
            5'd10:   a = 23'h000400;
            5'd11:   a = 23'h000200;
            5'd12:   a = 23'h000100;
            5'd13:   a = 23'h000080;
            5'd14:   a = 23'h000040;
            5'd15:   a = 23'h000020;
            default: a = '0;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/cordic_vec_stage.sv
// One combinational vectoring micro-rotation.
//   x, y   in  : vector before this stage (signed Q2.20)
//   z      in  : accumulated angle before this stage (signed Q2.20 rad)
//   shift  in  : iteration index i
//   angle  in  : atan(2^-i) in Q2.20
//   x_nxt, y_nxt, z_nxt out : vector and angle after this stage
// The rotation direction drives y toward zero; x' and y' both use the
// pre-stage x and y.
module cordic_vec_stage
    import cordic_pkg::*;
(
    input  logic signed [XYW-1:0] x,
    input  logic signed [XYW-1:0] y,
    input  logic signed [ZW-1:0]  z,
    input  logic [IdxW-1:0]       shift,
    input  logic signed [ZW-1:0]  angle,
    output logic signed [XYW-1:0] x_nxt,
    output logic signed [XYW-1:0] y_nxt,
    output logic signed [ZW-1:0]  z_nxt
);

    logic signed [XYW-1:0] x_sh;
    logic signed [XYW-1:0] y_sh;

    always_comb begin
        x_sh = x >>> shift;
        y_sh = y >>> shift;
        if (!y[XYW-1]) begin
            x_nxt = x + y_sh;
            y_nxt = y - x_sh;
            z_nxt = z + angle;
        end else begin
            x_nxt = x - y_sh;
            y_nxt = y + x_sh;
            z_nxt = z - angle;
        end
    end

endmodule

// File: rtl/cordic_atan_vec.sv
// Vectoring-mode CORDIC arctangent as a multi-cycle start/done slave.
//   clock   in  : clock
//   aclr    in  : synchronous active-high reset (overrides clk_en)
//   clk_en  in  : advance enable; all state frozen when low
//   start   in  : load new operands, aborting any operation in flight
//   dataa   in  : x operand, IEEE single (legal 0 < x < 1)
//   datab   in  : y operand, IEEE single (legal -1 < y < 1)
//   result  out : atan(y/x) as IEEE single, quiet NaN for illegal operands
//   done    out : result valid; held until next start or aclr
// Unrolls micro-rotations are chained per enabled cycle; done rises
// Iters/Unrolls+2 enabled edges after the start edge.
module cordic_atan_vec
    import cordic_pkg::*;
#(
    parameter int unsigned Unrolls = 4,
    parameter int unsigned Iters   = 16
) (
    input  logic        clock,
    input  logic        aclr,
    input  logic        clk_en,
    input  logic        start,
    input  logic [31:0] dataa,
    input  logic [31:0] datab,
    output logic [31:0] result,
    output logic        done
);

    localparam int unsigned IterW = $clog2(Iters + 1);

    // IEEE single -> signed Q2.20, truncating toward zero. Denormals flush
    // to zero and magnitudes >= 1.0 saturate to 1 - 2^-20.
    function automatic logic signed [XYW-1:0] fix_f32(input logic [31:0] f);
        logic [7:0]     e;
        logic [23:0]    mant;
        logic [23:0]    mag;
        logic [7:0]     sh;
        logic [XYW-1:0] m;
        e    = f[30:23];
        mant = {1'b1, f[22:0]};
        sh   = '0;
        if (e == 8'd0) begin
            mag = '0;
        end else if (e >= 8'd127) begin
            mag = 24'((1 << FRAC) - 1);
        end else begin
            // Exponent 127 - k aligns the hidden bit k places below the
            // binary point of a FRAC-bit fraction.
            sh  = 8'(127 + 23 - FRAC) - e;
            mag = (sh > 8'd23) ? '0 : (mant >> sh);
        end
        m = XYW'(mag);
        return f[31] ? (~m + 1'b1) : m;
    endfunction

    // Signed Q2.20 -> IEEE single, mantissa truncated.
    function automatic logic [31:0] flt_fix(input logic signed [ZW-1:0] z);
        logic [ZW-1:0]   mag;
        logic [4:0]      p;
        logic [2*ZW-1:0] sh;
        logic [7:0]      e;
        mag = z[ZW-1] ? ZW'(-z) : ZW'(z);
        p   = '0;
        for (int b = 0; b < int'(ZW); b++) begin
            if (mag[b]) p = 5'(b);
        end
        // Move the leading one to bit 23 so bits [22:0] are the fraction.
        sh = {{ZW{1'b0}}, mag} << (23 - int'(p));
        e  = 8'(127 - FRAC) + 8'(p);
        if (mag == '0) return 32'h0;
        return {z[ZW-1], e, sh[22:0]};
    endfunction

    state_e                state_q, state_d;
    logic [IterW-1:0]      iter_q, iter_d;
    logic signed [XYW-1:0] x_q, x_d;
    logic signed [XYW-1:0] y_q, y_d;
    logic signed [ZW-1:0]  z_q, z_d;
    logic                  err_q, err_d;
    logic [31:0]           result_q, result_d;
    logic                  done_q, done_d;

    logic                  operand_err;

    logic signed [XYW-1:0] x_s [Unrolls+1];
    logic signed [XYW-1:0] y_s [Unrolls+1];
    logic signed [ZW-1:0]  z_s [Unrolls+1];

    assign x_s[0] = x_q;
    assign y_s[0] = y_q;
    assign z_s[0] = z_q;

    for (genvar k = 0; k < Unrolls; k++) begin : g_stage
        logic [IdxW-1:0] idx;
        assign idx = IdxW'(iter_q) + IdxW'(k);

        cordic_vec_stage u_stage (
            .x     (x_s[k]),
            .y     (y_s[k]),
            .z     (z_s[k]),
            .shift (idx),
            .angle (atan_lut(idx)),
            .x_nxt (x_s[k+1]),
            .y_nxt (y_s[k+1]),
            .z_nxt (z_s[k+1])
        );
    end

    // x must be strictly positive and finite; y only needs to be finite.
    assign operand_err = dataa[31] || (dataa[30:23] == 8'h00) ||
                         (dataa[30:23] == 8'hFF) || (datab[30:23] == 8'hFF);

    always_comb begin
        state_d  = state_q;
        iter_d   = iter_q;
        x_d      = x_q;
        y_d      = y_q;
        z_d      = z_q;
        err_d    = err_q;
        result_d = result_q;
        done_d   = done_q;

        if (start) begin
            // Abort-and-reload from any state; result keeps its old value.
            state_d = StRun;
            iter_d  = '0;
            x_d     = fix_f32(dataa);
            y_d     = fix_f32(datab);
            z_d     = '0;
            err_d   = operand_err;
            done_d  = 1'b0;
        end else begin
            case (state_q)
                StRun: begin
                    if (iter_q == IterW'(Iters)) begin
                        state_d = StFin;
                    end else begin
                        x_d    = x_s[Unrolls];
                        y_d    = y_s[Unrolls];
                        z_d    = z_s[Unrolls];
                        iter_d = iter_q + IterW'(Unrolls);
                    end
                end
                StFin: begin
                    result_d = err_q ? NAN_Q : flt_fix(z_q);
                    done_d   = 1'b1;
                    state_d  = StDone;
                end
                StIdle, StDone: begin
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (aclr) begin
            state_q  <= StIdle;
            iter_q   <= '0;
            x_q      <= '0;
            y_q      <= '0;
            z_q      <= '0;
            err_q    <= 1'b0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else if (clk_en) begin
            state_q  <= state_d;
            iter_q   <= iter_d;
            x_q      <= x_d;
            y_q      <= y_d;
            z_q      <= z_d;
            err_q    <= err_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    assign result = result_q;
    assign done   = done_q;

endmodule

// File: tb/tb_cordic_atan_vec.sv
// Self-checking bench for cordic_atan_vec: expected angles from $atan2 are
// queued at each start and popped when done rises.
module tb_cordic_atan_vec;

    localparam int unsigned Unrolls = 4;
    localparam int unsigned Iters   = 16;
    localparam int          Lat     = Iters / Unrolls + 2;
    localparam longint      Tol     = 2048;  // 2^-13 rad in 2^-24 units

    typedef struct {
        logic is_nan;
        real  ang;
    } exp_t;

    logic        clock = 1'b0;
    logic        aclr;
    logic        clk_en;
    logic        start;
    logic [31:0] dataa;
    logic [31:0] datab;
    logic [31:0] result;
    logic        done;

    int          n_vec  = 0;
    int          n_miss = 0;
    exp_t        sb[$];
    exp_t        last_exp;
    logic [31:0] t1_res;

    cordic_atan_vec #(
        .Unrolls (Unrolls),
        .Iters   (Iters)
    ) dut (
        .clock  (clock),
        .aclr   (aclr),
        .clk_en (clk_en),
        .start  (start),
        .dataa  (dataa),
        .datab  (datab),
        .result (result),
        .done   (done)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input longint obs, input longint exp,
                         input longint tol);
        n_vec++;
        if (obs > exp + tol || obs < exp - tol) begin
            n_miss++;
            $display("FAIL %s: got %0d, want %0d (+/- %0d)", tag, obs, exp, tol);
        end
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    function automatic real f32_to_real(input logic [31:0] f);
        int  e;
        real m;
        e = int'(f[30:23]);
        if (e == 0) return 0.0;
        m = (1.0 + real'(f[22:0]) / 8388608.0) * (2.0 ** (e - 127));
        return f[31] ? -m : m;
    endfunction

    function automatic longint ang_units(input real r);
        return longint'($rtoi(r * 16777216.0));
    endfunction

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        e.is_nan = a[31] || (a[30:23] == 8'h00) || (a[30:23] == 8'hFF) ||
                   (b[30:23] == 8'hFF);
        e.ang    = e.is_nan ? 0.0 : $atan2(f32_to_real(b), f32_to_real(a));
        return e;
    endfunction

    task automatic check_result(input string tag, input exp_t e);
        longint obs;
        if (e.is_nan) begin
            check({tag, "_nan"}, longint'(result), longint'(32'h7FC0_0000), 0);
        end else begin
            obs = (result[30:23] == 8'hFF) ? (longint'(1) <<< 40)
                                            : ang_units(f32_to_real(result));
            check({tag, "_ang"}, obs, ang_units(e.ang), Tol);
        end
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input int stall_at, input int stall_len, input string tag);
        exp_t e;
        int   got;
        sb.push_back(model(a, b));
        dataa  = a;
        datab  = b;
        start  = 1'b1;
        clk_en = 1'b1;
        tick();
        start = 1'b0;
        check({tag, "_drop"}, longint'(done), 0, 0);
        // Previous result must hold until the new operation finishes.
        check_result({tag, "_hold"}, last_exp);
        got = 0;
        for (int ed = 1; ed <= Lat + stall_len + 20; ed++) begin
            clk_en = (ed > stall_at && ed <= stall_at + stall_len) ? 1'b0 : 1'b1;
            tick();
            if (done) begin
                got = ed;
                break;
            end
        end
        clk_en = 1'b1;
        check({tag, "_lat"}, longint'(got), longint'(Lat + stall_len), 0);
        e = sb.pop_front();
        if (got != 0) begin
            check_result(tag, e);
            last_exp = e;
        end
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;

        aclr   = 1'b1;
        clk_en = 1'b0;
        start  = 1'b0;
        dataa  = '0;
        datab  = '0;
        repeat (3) tick();
        check("rst_done", longint'(done), 0, 0);
        check("rst_result", longint'(result), 0, 0);
        aclr   = 1'b0;
        clk_en = 1'b1;
        tick();
        last_exp.is_nan = 1'b0;
        last_exp.ang    = 0.0;

        // Basic octant cases and sign.
        run_op(32'h3F00_0000, 32'h3F00_0000, 0, 0, "t1");
        t1_res = result;
        run_op(32'h3F00_0000, 32'hBF00_0000, 0, 0, "t2");
        check("t2_sign", longint'(result[31]), 1, 0);

        // Zero y, illegal operands, denormal y.
        run_op(32'h3F00_0000, 32'h0000_0000, 0, 0, "t3_y0");
        run_op(32'h0000_0000, 32'h3F00_0000, 0, 0, "t3_x0");
        run_op(32'hBF00_0000, 32'h3F00_0000, 0, 0, "t3_xneg");
        run_op(32'h3F00_0000, 32'h7F80_0000, 0, 0, "t3_yinf");
        run_op(32'h7FC0_0000, 32'h3F00_0000, 0, 0, "t3_xnan");
        run_op(32'h3F00_0000, 32'h0000_0001, 0, 0, "t3_yden");

        // Stall mid-run: latency stretches, bits unchanged.
        run_op(32'h3F00_0000, 32'h3F00_0000, 2, 2, "t4");
        check("t4_bits", longint'(result), longint'(t1_res), 0);

        // Abort: restart at edge 3 with a different operand pair.
        dataa = 32'h3F00_0000;
        datab = 32'h3F00_0000;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int ed = 1; ed <= 2; ed++) begin
            tick();
            check("t5_nodone", longint'(done), 0, 0);
        end
        run_op(32'h3F00_0000, 32'h3E80_0000, 0, 0, "t5");

        // Reset at edge 2 of an operation, with clk_en low to show override.
        dataa = 32'h3F00_0000;
        datab = 32'h3F00_0000;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        aclr   = 1'b1;
        clk_en = 1'b0;
        tick();
        aclr   = 1'b0;
        clk_en = 1'b1;
        repeat (Lat + 4) tick();
        check("t5_clr_done", longint'(done), 0, 0);
        check("t5_clr_result", longint'(result), 0, 0);
        last_exp.is_nan = 1'b0;
        last_exp.ang    = 0.0;

        // Random legal pairs: x in [0.25,1), |y| in [1/32,1) or zero.
        for (int n = 0; n < 300; n++) begin
            ra = {1'b0, 8'(125 + $urandom_range(1)), 23'($urandom)};
            rb = {1'($urandom), 8'(122 + $urandom_range(4)), 23'($urandom)};
            if ($urandom_range(15) == 0) rb = '0;
            run_op(ra, rb, 0, 0, "rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
